apb_stdout_stream: RTL
======================

APB_STDOUT_STREAM -- requirements
Module: apb_stdout_stream

Interface
REQ-001 SHALL have parameter N_CORES, default 8, cores per cluster (1..16).
REQ-002 SHALL have parameter N_CLUSTERS, default 4, clusters (1..16).
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, APB address width (>=13).
REQ-004 SHALL have parameter DATA_WIDTH, default 32, APB data width (fixed 32).
REQ-005 SHALL have parameter FIFO_DEPTH, default 64, entries (power of 2, 2..32768).
REQ-006 SHALL have port clk_i  input  1  clock, all logic on rising edge.
REQ-007 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port apb  APB_BUS.Slave  ADDR_WIDTH/DATA_WIDTH  register and character access.
REQ-009 SHALL have port out_valid_o  output  1  FIFO head valid.
REQ-010 SHALL have port out_ready_i  input  1  consumer accepts head.
REQ-011 SHALL have port out_data_o  output  32  head entry: [7:0] char, [11:8] core, [15:12] cluster, [16] eol (char==0x0A), [31:17] zero.

Function
REQ-012 SHALL decode paddr[12]=0 as character region: cluster=paddr[10:7], core=paddr[6:3], char=pwdata[7:0].
REQ-013 SHALL decode paddr[12]=1 as register region: 0x1000 STATUS (RO), 0x1004 DROP_CNT (write clears), 0x1008 HIGH_WATER (write clears); other offsets read 0, writes ignored.
REQ-014 SHALL raise a push on a character-region write access phase (psel&penable&pwrite) with cluster<N_CLUSTERS and core<N_CORES.
REQ-015 SHALL drive pslverr=1 for character writes with out-of-range indices, no push; pslverr=0 otherwise.
REQ-016 SHALL pop when out_valid_o&out_ready_i; out_data_o SHALL hold stable while out_valid_o&!out_ready_i.
REQ-017 SHALL make a pushed entry visible on out_valid_o/out_data_o the cycle after the access phase (1-cycle latency, fall-through when empty).
REQ-018 SHALL accept a push when FIFO not full, or when full and a pop occurs in the same cycle (count unchanged).
REQ-019 SHALL preserve push order across all channels (single shared FIFO).
REQ-020 SHALL report STATUS [15:0] occupancy, [16] empty, [17] full, [31:18] zero.
REQ-021 SHALL update HIGH_WATER to max occupancy observed; clear-write in same cycle as new maximum SHALL load the new occupancy.
REQ-022 SHALL saturate DROP_CNT at 0xFFFFFFFF; clear-write simultaneous with drop SHALL yield 1.
REQ-023 SHALL return prdata=0 for character-region reads; all reads have no side effects.
REQ-024 SHALL drive pready=1 for all accesses except as in REQ-029.

Reset
REQ-025 SHALL on rst_ni low asynchronously empty the FIFO, zero DROP_CNT and HIGH_WATER, drive out_valid_o=0, out_data_o=0.
REQ-026 SHALL discard FIFO contents on reset mid-operation; no partial entry emitted after release.

Configuration
REQ-027 SHALL provide macro APB_STDOUT_BACKPRESSURE_EN selecting full-FIFO policy.
REQ-028 SHALL without APB_STDOUT_BACKPRESSURE_EN, on a rejected push (full, no pop), complete the access with pready=1, discard the char, increment DROP_CNT.
REQ-029 SHALL with APB_STDOUT_BACKPRESSURE_EN, drive pready=0 while a valid character write sees full and no pop, completing the access in the cycle a pop occurs; DROP_CNT SHALL stay 0.

Structure
REQ-030 SHALL place stdout_entry_t struct (char, core, cluster, eol) and register offset constants in package apb_stdout_pkg.
REQ-031 SHALL implement storage in sub-module stdout_fifo (generic sync FIFO: push/pop, full/empty, occupancy, DEPTH and type parameters).

Verification
REQ-032 SHALL cover: write 0x41 to addr 0x188 (cl 3, core 1), out_ready_i=1 -> next cycle out_data_o=0x00003141, valid one cycle.
REQ-033 SHALL cover: write 0x0A to 0x000 -> out_data_o=0x0001000A (eol set).
REQ-034 SHALL cover: write to cl 15 with N_CLUSTERS=4 -> pslverr=1, STATUS=0x00010000, no output.
REQ-035 SHALL cover: out_ready_i=0, FIFO_DEPTH+3 writes, no macro -> STATUS full, DROP_CNT=3, HIGH_WATER=FIFO_DEPTH; write 0x1004 -> DROP_CNT=0.
REQ-036 SHALL cover: macro defined, FIFO full, write pending -> pready=0 until out_ready_i pulse, then entry accepted, order preserved.
REQ-037 SHALL cover: rst_ni low with 5 entries queued -> out_valid_o=0, STATUS=0x00010000, HIGH_WATER=0 after release.

Source files
------------

// File: rtl/apb_stdout_pkg.sv
// Shared types and register map for the APB stdout character stream.
package apb_stdout_pkg;

  typedef struct packed {
    logic       eol;
    logic [3:0] cluster;
    logic [3:0] core;
    logic [7:0] ch;
  } stdout_entry_t;

  localparam logic [12:0] REG_STATUS     = 13'h1000;
  localparam logic [12:0] REG_DROP_CNT   = 13'h1004;
  localparam logic [12:0] REG_HIGH_WATER = 13'h1008;

  localparam logic [7:0] CHAR_LF = 8'h0A;

  function automatic stdout_entry_t make_entry(input logic [3:0] cl, input logic [3:0] co,
                                               input logic [7:0] c);
    stdout_entry_t e;
    e.eol     = (c == CHAR_LF);
    e.cluster = cl;
    e.core    = co;
    e.ch      = c;
    return e;
  endfunction

endpackage

// File: rtl/apb_bus.sv
// Minimal APB bus interface with master/slave views.
interface APB_BUS #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32
);
  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic [APB_DATA_WIDTH-1:0] pwdata;
  logic                      pwrite;
  logic                      psel;
  logic                      penable;
  logic [APB_DATA_WIDTH-1:0] prdata;
  logic                      pready;
  logic                      pslverr;

  modport Master (output paddr, pwdata, pwrite, psel, penable,
                  input  prdata, pready, pslverr);
  modport Slave  (input  paddr, pwdata, pwrite, psel, penable,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/stdout_fifo.sv
// Generic synchronous fall-through FIFO; a push while full is taken only alongside a pop.
module stdout_fifo #(
  parameter int  DEPTH = 64,
  parameter type T     = logic [7:0],
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          i_push,
  input  T              i_data,
  input  logic          i_pop,
  output T              o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_cnt
);

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_wr, w_rd;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_cnt   = r_cnt;
  assign o_data  = r_mem[r_rd];
  assign w_rd    = i_pop & ~o_empty;
  assign w_wr    = i_push & (~o_full | w_rd);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wr <= r_wr + AW'(1);
      if (w_rd) r_rd <= r_rd + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage needs no reset: the head is masked by o_empty downstream.
  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/apb_stdout_stream.sv
// APB character sink feeding one shared stdout stream FIFO, plus status/drop/high-water registers.
// Build option APB_STDOUT_BACKPRESSURE_EN: stall the APB write on a full FIFO instead of dropping.
module apb_stdout_stream
  import apb_stdout_pkg::*;
#(
  parameter int N_CORES    = 8,
  parameter int N_CLUSTERS = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  APB_BUS.Slave       apb,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [12:0]           w_off;
  logic [3:0]            w_cl, w_core;
  logic                  w_wr, w_chr_region, w_idx_ok, w_chr_wr;
  logic                  w_full, w_empty, w_pop, w_room, w_push, w_stall, w_drop;
  logic                  w_clr_drop, w_clr_hw;
  logic [CW-1:0]         w_cnt, w_occ_nxt;
  logic [31:0]           w_occ32, w_status;
  logic [DATA_WIDTH-1:0] w_prdata;
  stdout_entry_t         w_head, w_new;
  logic [31:0]           r_drop, r_hw;
  logic                  w_unused;

  assign w_off        = apb.paddr[12:0];
  assign w_cl         = apb.paddr[10:7];
  assign w_core       = apb.paddr[6:3];
  assign w_wr         = apb.psel & apb.penable & apb.pwrite;
  assign w_chr_region = ~w_off[12];
  assign w_idx_ok     = (32'(w_cl) < N_CLUSTERS) && (32'(w_core) < N_CORES);
  assign w_chr_wr     = w_wr & w_chr_region & w_idx_ok;
  assign w_new        = make_entry(w_cl, w_core, apb.pwdata[7:0]);
  assign w_unused     = ^{apb.paddr[ADDR_WIDTH-1:13], apb.pwdata[DATA_WIDTH-1:8], w_off[11]};

  assign w_pop  = ~w_empty & out_ready_i;
  assign w_room = ~w_full | w_pop;
  assign w_push = w_chr_wr & w_room;

`ifdef APB_STDOUT_BACKPRESSURE_EN
  assign w_stall = w_chr_wr & ~w_room;
  assign w_drop  = 1'b0;
`else
  assign w_stall = 1'b0;
  assign w_drop  = w_chr_wr & ~w_room;
`endif

  stdout_fifo #(.DEPTH(FIFO_DEPTH), .T(stdout_entry_t)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_push),
    .i_data  (w_new),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_cnt   (w_cnt)
  );

  assign out_valid_o = ~w_empty;
  assign out_data_o  = w_empty ? 32'h0 : {15'h0, w_head};

  // Occupancy after this edge, so a same-cycle clear still captures a new peak.
  always_comb begin
    w_occ_nxt = w_cnt;
    if (w_push & ~w_pop)      w_occ_nxt = w_cnt + CW'(1);
    else if (~w_push & w_pop) w_occ_nxt = w_cnt - CW'(1);
  end
  assign w_occ32 = 32'(w_occ_nxt);

  assign w_clr_drop = w_wr & (w_off == REG_DROP_CNT);
  assign w_clr_hw   = w_wr & (w_off == REG_HIGH_WATER);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_drop <= '0;
      r_hw   <= '0;
    end else begin
      if (w_clr_drop)                 r_drop <= w_drop ? 32'd1 : 32'd0;
      else if (w_drop && ~&r_drop)    r_drop <= r_drop + 32'd1;
      if (w_clr_hw)                   r_hw   <= (w_occ32 > r_hw) ? w_occ32 : 32'd0;
      else if (w_occ32 > r_hw)        r_hw   <= w_occ32;
    end
  end

  assign w_status = {14'h0, w_full, w_empty, 16'(w_cnt)};

  always_comb begin
    w_prdata = '0;
    case (w_off)
      REG_STATUS:     w_prdata = DATA_WIDTH'(w_status);
      REG_DROP_CNT:   w_prdata = DATA_WIDTH'(r_drop);
      REG_HIGH_WATER: w_prdata = DATA_WIDTH'(r_hw);
      default:        w_prdata = '0;
    endcase
  end

  assign apb.prdata  = w_prdata;
  assign apb.pready  = ~w_stall;
  assign apb.pslverr = w_wr & w_chr_region & ~w_idx_ok;

endmodule
